stream_comparator: RTL
======================

STREAM_COMPARATOR -- requirements
Module: stream_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal 2..32.
REQ-002 Parameter CNT_W, default 16: statistics counter width, legal 4..32.
REQ-003 Clk  input  1  sole clock; all state on rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  one-cycle pulse; begins a run and clears statistics.
REQ-006 SignedMode  input  1  1 = two's-complement compare, 0 = unsigned; sampled per accepted pair.
REQ-007 InValid  input  1  DOut2/DOut1/Last valid.
REQ-008 InReady  output  1  block can accept a pair.
REQ-009 DOut2, DOut1  input  WIDTH each  operands compared as DOut2 versus DOut1.
REQ-010 Last  input  1  marks final pair of the run.
REQ-011 ResValid  output  1  Sign/Equal hold a valid result.
REQ-012 ResReady  input  1  downstream accepts the result.
REQ-013 Sign  output  1  1 when DOut2 < DOut1.
REQ-014 Equal  output  1  1 when DOut2 == DOut1.
REQ-015 LtCount, EqCount, GtCount  output  CNT_W each  per-run outcome counters.
REQ-016 Done  output  1  high from run completion until next Start.
REQ-017 MaxVal, MinVal  output  WIDTH each  running extremes of DOut2 (see Configuration).

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on Start; RUN->DONE when pair with Last=1 is accepted; DONE->RUN on Start.
REQ-019 Start in RUN restarts the run: counters and extremes cleared, any pair offered that cycle is not accepted, state stays RUN.
REQ-020 InReady = (state==RUN) && !Start && (!ResValid || ResReady).
REQ-021 Pair accepted when InValid && InReady; Sign/Equal/ResValid registered on that edge, so latency is exactly 1 cycle.
REQ-022 ResValid clears on ResValid && ResReady with no new accept that cycle; simultaneous retire and accept keeps ResValid=1 with new result.
REQ-023 Sign/Equal hold stable while ResValid && !ResReady.
REQ-024 Each accepted pair increments exactly one of LtCount, EqCount, GtCount, visible the cycle after accept.
REQ-025 Counters saturate at all-ones; no wrap-around.
REQ-026 Signed compare treats bit WIDTH-1 as sign; unsigned compares full magnitude; SignedMode affects only the pair accepted with it.
REQ-027 Done set on the edge accepting Last, cleared on Start; counters hold their values while Done=1.
REQ-028 Start in IDLE or DONE clears counters on the same edge as the state change.

Reset
REQ-029 Rst_n low asynchronously forces state IDLE, InReady=0, ResValid=0, Sign=0, Equal=0, Done=0, all counters 0, MaxVal=0, MinVal=0.
REQ-030 Reset asserted mid-run discards the in-flight result; after release the block waits for Start.

Configuration
REQ-031 Macro STREAM_CMP_MINMAX_EN defined: MaxVal/MinVal track max/min of accepted DOut2 under that pair's SignedMode; first pair of a run loads both; cleared to 0 on Start.
REQ-032 Macro STREAM_CMP_MINMAX_EN undefined: ports retained, MaxVal and MinVal tied to 0, no tracking logic.

Verification
REQ-033 WIDTH=8, Start, pairs (0,1),(0,0),(1,0) unsigned, Last on third -> Sign 1,0,0; Equal 0,1,0; Lt=1 Eq=1 Gt=1; Done=1.
REQ-034 Pair (8'h80, 8'h01): SignedMode=1 -> Sign=1; SignedMode=0 -> Sign=0.
REQ-035 ResReady=0 for 3 cycles after first result -> InReady=0, Sign/Equal stable; ResReady=1 -> next pair accepted same cycle.
REQ-036 CNT_W=4, 20 equal pairs -> EqCount stops at 15.
REQ-037 Rst_n low mid-run after 2 pairs -> all outputs 0 immediately; InReady stays 0 until Start.
REQ-038 With STREAM_CMP_MINMAX_EN, unsigned DOut2 sequence 5,200,3 -> MaxVal=200, MinVal=3; without macro both 0.

Source files
------------

// File: rtl/stream_comparator.sv
// Streaming two-operand comparator with per-run Lt/Eq/Gt counters. Result latency is 1 cycle; InReady drops while a result is stalled.
// Optional running max/min of DOut2 is enabled by defining STREAM_CMP_MINMAX_EN; otherwise MaxVal/MinVal are tied to 0.
module stream_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             SignedMode,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] DOut2,
  input  logic [WIDTH-1:0] DOut1,
  input  logic             Last,
  output logic             ResValid,
  input  logic             ResReady,
  output logic             Sign,
  output logic             Equal,
  output logic [CNT_W-1:0] LtCount,
  output logic [CNT_W-1:0] EqCount,
  output logic [CNT_W-1:0] GtCount,
  output logic             Done,
  output logic [WIDTH-1:0] MaxVal,
  output logic [WIDTH-1:0] MinVal
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             res_vld_q, res_vld_d;
  logic             sign_q, sign_d;
  logic             equal_q, equal_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic             accept;
  logic             pair_lt;
  logic             pair_eq;

  // With differing sign bits in signed mode, the negative operand is the smaller one.
  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic sgn);
    if (sgn && (a[WIDTH-1] != b[WIDTH-1])) return a[WIDTH-1];
    return a < b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  assign InReady = (state_q == RUN) && !Start && (!res_vld_q || ResReady);
  assign accept  = InValid && InReady;
  assign pair_lt = less_than(DOut2, DOut1, SignedMode);
  assign pair_eq = (DOut2 == DOut1);

  always_comb begin
    state_d   = state_q;
    res_vld_d = res_vld_q;
    sign_d    = sign_q;
    equal_d   = equal_q;
    lt_cnt_d  = lt_cnt_q;
    eq_cnt_d  = eq_cnt_q;
    gt_cnt_d  = gt_cnt_q;

    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (accept && Last) state_d = DONE;
      DONE:    if (Start) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (Start) begin
      lt_cnt_d = '0;
      eq_cnt_d = '0;
      gt_cnt_d = '0;
    end else if (accept) begin
      if (pair_eq)      eq_cnt_d = sat_inc(eq_cnt_q);
      else if (pair_lt) lt_cnt_d = sat_inc(lt_cnt_q);
      else              gt_cnt_d = sat_inc(gt_cnt_q);
    end

    // A new accept overrides a retiring result; otherwise the result is held until taken.
    if (accept) begin
      res_vld_d = 1'b1;
      sign_d    = pair_lt;
      equal_d   = pair_eq;
    end else if (ResReady) begin
      res_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      res_vld_q <= 1'b0;
      sign_q    <= 1'b0;
      equal_q   <= 1'b0;
      lt_cnt_q  <= '0;
      eq_cnt_q  <= '0;
      gt_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      res_vld_q <= res_vld_d;
      sign_q    <= sign_d;
      equal_q   <= equal_d;
      lt_cnt_q  <= lt_cnt_d;
      eq_cnt_q  <= eq_cnt_d;
      gt_cnt_q  <= gt_cnt_d;
    end
  end

  assign ResValid = res_vld_q;
  assign Sign     = sign_q;
  assign Equal    = equal_q;
  assign LtCount  = lt_cnt_q;
  assign EqCount  = eq_cnt_q;
  assign GtCount  = gt_cnt_q;
  assign Done     = (state_q == DONE);

`ifdef STREAM_CMP_MINMAX_EN
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic             first_q, first_d;

  always_comb begin
    max_d   = max_q;
    min_d   = min_q;
    first_d = first_q;
    if (Start) begin
      max_d   = '0;
      min_d   = '0;
      first_d = 1'b1;
    end else if (accept) begin
      first_d = 1'b0;
      // The first pair of a run seeds both extremes regardless of their cleared value.
      if (first_q || less_than(max_q, DOut2, SignedMode)) max_d = DOut2;
      if (first_q || less_than(DOut2, min_q, SignedMode)) min_d = DOut2;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      max_q   <= '0;
      min_q   <= '0;
      first_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      min_q   <= min_d;
      first_q <= first_d;
    end
  end

  assign MaxVal = max_q;
  assign MinVal = min_q;
`else
  assign MaxVal = '0;
  assign MinVal = '0;
`endif

endmodule
